// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: credit-based fetch front end with a DEPTH-entry prefetch queue.
// Optional build macro IF_PREFETCH_BYPASS_EN forwards a response to decode when the queue is empty.
module if_prefetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc4,
  output logic [ADDR_W-1:0] dec_pc8
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     q_cnt;
  logic [PW-1:0]     q_wp, q_rp;
  logic [PW-1:0]     tag_wp, tag_rp;
  logic [ADDR_W-1:0] tag_mem [DEPTH];
  logic [ADDR_W-1:0] q_pc [DEPTH];
  logic [DATA_W-1:0] q_instr [DEPTH];

  logic              q_empty;
  logic              rsp_keep;
  logic              byp;
  logic              q_push;
  logic              q_pop;
  logic              req_fire;
  logic [CW:0]       used;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_instr;

  // credit check, head selection and handshake decode
  always_comb begin
    q_empty  = (q_cnt == '0);
    used     = {1'b0, q_cnt} + {1'b0, inflight};
    rsp_keep = imem_rsp_valid && (drop == '0) && !redir_valid;
    byp      = 1'b0;
`ifdef IF_PREFETCH_BYPASS_EN
    byp      = rsp_keep && q_empty;
`endif
    head_pc    = q_pc[q_rp];
    head_instr = q_instr[q_rp];
    if (byp) begin
      head_pc    = tag_mem[tag_rp];
      head_instr = imem_rsp_data;
    end
    imem_req_valid = reset && !redir_valid && (used < DEPTH_C);
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    dec_valid      = reset && (!q_empty || byp);
    dec_instr      = dec_valid ? head_instr : '0;
    dec_pc4        = dec_valid ? head_pc + ADDR_W'(4) : '0;
    dec_pc8        = dec_valid ? head_pc + ADDR_W'(8) : '0;
    q_pop          = !q_empty && dec_ready;
    q_push         = rsp_keep && !(byp && dec_ready);
  end

  // fetch pointer, credit counters and queue pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      q_cnt    <= '0;
      q_wp     <= '0;
      q_rp     <= '0;
      tag_wp   <= '0;
      tag_rp   <= '0;
    end else begin
      assert (!(q_push && !q_pop && q_cnt == CW'(DEPTH)));
      if (redir_valid)
        fetch_pc <= redir_pc & ~ADDR_W'(3);
      else if (req_fire)
        fetch_pc <= fetch_pc + ADDR_W'(4);
      if (req_fire)
        tag_wp <= tag_wp + 1'b1;
      if (imem_rsp_valid)
        tag_rp <= tag_rp + 1'b1;
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redir_valid)
        drop <= inflight - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && drop != '0)
        drop <= drop - 1'b1;
      if (redir_valid) begin
        q_cnt <= '0;
        q_wp  <= '0;
        q_rp  <= '0;
      end else begin
        if (q_push)
          q_wp <= q_wp + 1'b1;
        if (q_pop)
          q_rp <= q_rp + 1'b1;
        q_cnt <= q_cnt + CW'(q_push) - CW'(q_pop);
      end
    end
  end

  // tag and queue storage (contents are don't-care until counted valid)
  always_ff @(posedge clk) begin
    if (req_fire)
      tag_mem[tag_wp] <= fetch_pc;
    if (q_push) begin
      q_pc[q_wp]    <= tag_mem[tag_rp];
      q_instr[q_wp] <= imem_rsp_data;
    end
  end

endmodule
